uart_receiver_ext: RTL and testbench

Parametrised successor to the team's fixed-format 8-bit UART receiver. Supports runtime-selectable data width (5-9 bits), parity mode (none/even/odd) and stop bits (1/2), with majority-vote mid-bit sampling, false-start rejection and break detection. Received frames, with their per-frame error flags, are buffered in an internal FIFO drained by a valid/ready handshake. Sits between the RxD pin synchroniser domain and the system-side consumer.

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_rx_fifo.sv | 65 ++++++
 rtl/uart_receiver_ext.sv | 219 +++++++++++++++++++++
 tb/tb_uart_receiver_ext.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the extended UART receiver.
// Baud divisor table, parity encodings, FSM states, FIFO entry layout.
package uart_pkg;

  localparam int DATA_W  = 9;
  localparam int ENTRY_W = 12;
  localparam int DIV_W   = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_PUSH,
    ST_WAIT_HIGH
  } state_t;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    int unsigned b;
    case (sel)
      3'd0:    b = 300;
      3'd1:    b = 1200;
      3'd2:    b = 4800;
      3'd3:    b = 9600;
      3'd4:    b = 19200;
      3'd5:    b = 38400;
      3'd6:    b = 57600;
      default: b = 115200;
    endcase
    return b;
  endfunction

  // Rounded clocks per oversample tick.
  function automatic int unsigned baud_div(
    input int unsigned clk_hz,
    input int unsigned os,
    input logic [2:0]  sel
  );
    int unsigned d;
    d = baud_rate(sel) * os;
    return (clk_hz + d / 2) / d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Frame FIFO for the UART receiver.
// Head entry and valid flag come straight from registers.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nx;
  logic [AW:0]      count;
  logic [AW:0]      count_nx;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign rd_nx    = rd_ptr + AW'(pop_ok);
  assign count_nx = count + (AW+1)'(push_ok)
                  - (AW+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nx;
      count  <= count_nx;
      valid  <= (count_nx != '0);
      // Bypass when the entry being written becomes the new head.
      if (count_nx == '0)
        head <= '0;
      else if (push_ok && wr_ptr == rd_nx)
        head <= wdata;
      else
        head <= mem[rd_nx];
    end
  end

endmodule

// File: rtl/uart_receiver_ext.sv
// Configurable UART receiver: 5-9 data bits, parity, 1/2 stop bits,
// majority-vote sampling, break detection and a frame FIFO.
import uart_pkg::*;

module uart_receiver_ext #(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX_EN,
  input  logic       RxD,
  input  logic [2:0] baud_select,
  input  logic [1:0] data_bits,
  input  logic       nine_bit,
  input  logic [1:0] parity_mode,
  input  logic       stop_two,
  output logic [8:0] Rx_DATA,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BREAK,
  output logic       Rx_VALID,
  input  logic       Rx_READY,
  output logic       Rx_OVERRUN,
  input  logic       ovr_clr
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] S_LO  = SCW'(OVERSAMPLE/2 - 1);
  localparam logic [SCW-1:0] S_MID = SCW'(OVERSAMPLE/2);
  localparam logic [SCW-1:0] S_HI  = SCW'(OVERSAMPLE/2 + 1);
  localparam logic [SCW-1:0] S_END = SCW'(OVERSAMPLE - 1);

  state_t state, state_nx;

  logic             sync1, rxs, rxs_q;
  logic [DIV_W-1:0] div_tab [8];
  logic [DIV_W-1:0] cnt;
  logic [SCW-1:0]   sc;
  logic [2:0]       smp;
  logic [2:0]       cfg_baud;
  logic [1:0]       cfg_par;
  logic             cfg_stop2;
  logic [3:0]       nbits, bit_idx;
  logic [8:0]       shreg;
  logic             par_acc, perr, ferr;
  logic             all_zero, last_low;
  logic             run, tick, samp, bit_end;
  logic             fall, start, maj, par_en;
  logic             push, ovr_set;
  logic             fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] entry, head;

  for (genvar g = 0; g < 8; g++) begin : g_div
    assign div_tab[g] =
      DIV_W'(baud_div(CLK_HZ, OVERSAMPLE, 3'(g)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync1 <= RxD;
      rxs   <= sync1;
      rxs_q <= rxs;
    end
  end

  assign fall    = rxs_q && !rxs;
  assign start   = (state == ST_IDLE) && RX_EN && fall;
  assign run     = RX_EN && (state != ST_IDLE);
  assign tick    = run && (cnt == div_tab[cfg_baud] - DIV_W'(1));
  assign samp    = tick && (sc == S_LO || sc == S_MID || sc == S_HI);
  assign bit_end = tick && (sc == S_END);
  assign maj     = (smp[0] & smp[1]) | (smp[0] & smp[2])
                 | (smp[1] & smp[2]);
  assign par_en  = (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);

  always_ff @(posedge clk) begin
    if (reset || !run || tick) cnt <= '0;
    else                       cnt <= cnt + DIV_W'(1);
  end

  // In WAIT_HIGH the sub-bit count only advances while the line is high.
  always_ff @(posedge clk) begin
    if (reset || !run || state == ST_PUSH)
      sc <= '0;
    else if (state == ST_WAIT_HIGH && !rxs)
      sc <= '0;
    else if (tick)
      sc <= (sc == S_END) ? '0 : sc + SCW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)     smp <= '0;
    else if (samp) smp <= {smp[1:0], rxs};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (start) state_nx = ST_START;
      ST_START:
        if (bit_end) state_nx = maj ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (bit_end && bit_idx == nbits - 4'd1)
          state_nx = par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY:
        if (bit_end) state_nx = ST_STOP1;
      ST_STOP1:
        if (bit_end)
          state_nx = cfg_stop2 ? ST_STOP2 : ST_PUSH;
      ST_STOP2:
        if (bit_end) state_nx = ST_PUSH;
      ST_PUSH:
        state_nx = last_low ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH:
        if (bit_end && rxs) state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
    if (!RX_EN) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_baud  <= '0;
      cfg_par   <= PAR_NONE;
      cfg_stop2 <= 1'b0;
      nbits     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      all_zero  <= 1'b0;
      last_low  <= 1'b0;
    end else if (start) begin
      cfg_baud  <= baud_select;
      cfg_par   <= parity_mode;
      cfg_stop2 <= stop_two;
      nbits     <= nine_bit ? 4'd9
                            : 4'd5 + {2'b00, data_bits};
      bit_idx   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      all_zero  <= 1'b1;
      last_low  <= 1'b0;
    end else if (bit_end) begin
      case (state)
        ST_DATA: begin
          shreg[bit_idx] <= maj;
          par_acc        <= par_acc ^ maj;
          all_zero       <= all_zero & ~maj;
          bit_idx        <= bit_idx + 4'd1;
        end
        ST_PARITY: begin
          perr     <= par_acc ^ maj ^ (cfg_par == PAR_ODD);
          all_zero <= all_zero & ~maj;
        end
        ST_STOP1: begin
          if (!maj) ferr <= 1'b1;
          all_zero <= all_zero & ~maj;
          last_low <= ~maj;
        end
        ST_STOP2: begin
          if (!maj) ferr <= 1'b1;
          last_low <= ~maj;
        end
        default: ;
      endcase
    end
  end

  assign push  = (state == ST_PUSH);
  assign entry = all_zero ? {9'd0, perr, 1'b1, 1'b1}
                          : {shreg, perr, ferr, 1'b0};

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (entry),
    .pop   (Rx_READY && !fifo_empty),
    .head  (head),
    .valid (Rx_VALID),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Rx_DATA   = head[11:3];
  assign Rx_PERROR = head[2];
  assign Rx_FERROR = head[1];
  assign Rx_BREAK  = head[0];

  assign ovr_set = push && fifo_full
                && !(Rx_READY && !fifo_empty);

  always_ff @(posedge clk) begin
    if (reset)        Rx_OVERRUN <= 1'b0;
    else if (ovr_set) Rx_OVERRUN <= 1'b1;
    else if (ovr_clr) Rx_OVERRUN <= 1'b0;
  end

endmodule

// File: tb/tb_uart_receiver_ext.sv
// Directed bench for uart_receiver_ext at 64 clocks per bit
// (115200 baud) and 128 clocks per bit (57600 baud).
import uart_pkg::*;

module tb_uart_receiver_ext;

  localparam int CLK_HZ = 7372800;
  localparam int OS     = 16;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset, RX_EN, RxD;
  logic [2:0] baud_select;
  logic [1:0] data_bits, parity_mode;
  logic       nine_bit, stop_two;
  logic [8:0] Rx_DATA;
  logic       Rx_PERROR, Rx_FERROR, Rx_BREAK;
  logic       Rx_VALID, Rx_READY, Rx_OVERRUN, ovr_clr;

  int n_run  = 0;
  int n_fail = 0;
  int bitc   = 64;
  bit ok;

  always #5 clk = ~clk;

  uart_receiver_ext #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .RX_EN       (RX_EN),
    .RxD         (RxD),
    .baud_select (baud_select),
    .data_bits   (data_bits),
    .nine_bit    (nine_bit),
    .parity_mode (parity_mode),
    .stop_two    (stop_two),
    .Rx_DATA     (Rx_DATA),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_BREAK    (Rx_BREAK),
    .Rx_VALID    (Rx_VALID),
    .Rx_READY    (Rx_READY),
    .Rx_OVERRUN  (Rx_OVERRUN),
    .ovr_clr     (ovr_clr)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    cyc(n);
  endtask

  // Serialise v[0..n-1]; bit gbit gets a 3-clock inverted pulse
  // that overlaps only its first mid-bit sample.
  task automatic tx(input logic [15:0] v, input int n,
                    input int gbit);
    for (int i = 0; i < n; i++) begin
      RxD = v[i];
      if (i == gbit) begin
        cyc(30);
        RxD = ~v[i];
        cyc(3);
        RxD = v[i];
        cyc(bitc - 33);
      end else begin
        cyc(bitc);
      end
    end
  endtask

  task automatic head(input string tag, input logic [8:0] d,
                      input logic p, input logic f,
                      input logic b);
    check({tag, "_v"}, 16'(Rx_VALID), 16'd1);
    check({tag, "_d"}, 16'(Rx_DATA), 16'(d));
    check({tag, "_pfb"},
          16'({Rx_PERROR, Rx_FERROR, Rx_BREAK}),
          16'({p, f, b}));
  endtask

  task automatic pop;
    Rx_READY = 1'b1;
    cyc(1);
    Rx_READY = 1'b0;
    cyc(1);
  endtask

  task automatic wait_push(output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      if (dut.state == ST_PUSH) hit = 1'b1;
      else cyc(1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; RX_EN = 1'b1; RxD = 1'b1;
    baud_select = 3'd7; data_bits = 2'b11;
    nine_bit = 1'b0; parity_mode = PAR_EVEN;
    stop_two = 1'b0; Rx_READY = 1'b0; ovr_clr = 1'b0;
    cyc(4);
    check("reset_out",
          16'({Rx_VALID, Rx_OVERRUN, Rx_PERROR,
               Rx_FERROR, Rx_BREAK, Rx_DATA}), 16'd0);
    check("reset_st", 16'(dut.state), 16'(ST_IDLE));
    reset = 1'b0;
    idle(20);

    // 8E1 0x85, even parity bit 1
    tx({5'd0, 1'b1, 1'b1, 8'h85, 1'b0}, 11, -1);
    idle(16);
    head("8e1", 9'h085, 1'b0, 1'b0, 1'b0);
    pop();
    check("8e1_empty", 16'(Rx_VALID), 16'd0);

    tx({5'd0, 1'b1, 1'b0, 8'h85, 1'b0}, 11, -1);
    idle(16);
    head("perr", 9'h085, 1'b1, 1'b0, 1'b0);
    pop();

    parity_mode = PAR_ODD;
    tx({5'd0, 1'b1, 1'b0, 8'h85, 1'b0}, 11, -1);
    idle(16);
    head("odd", 9'h085, 1'b0, 1'b0, 1'b0);
    pop();
    parity_mode = PAR_EVEN;

    // 160 ns low glitch on idle line
    RxD = 1'b0;
    cyc(16);
    idle(200);
    check("glitch_v", 16'(Rx_VALID), 16'd0);
    check("glitch_st", 16'(dut.state), 16'(ST_IDLE));

    // one mid-bit sample of D0 corrupted
    tx({5'd0, 1'b1, 1'b1, 8'h85, 1'b0}, 11, 1);
    idle(16);
    head("vote", 9'h085, 1'b0, 1'b0, 1'b0);
    pop();

    // 8N2 with second stop bit low
    parity_mode = PAR_NONE;
    stop_two = 1'b1;
    tx({5'd0, 1'b0, 1'b1, 8'h5A, 1'b0}, 11, -1);
    cyc(16);
    head("stop2", 9'h05A, 1'b0, 1'b1, 1'b0);
    check("wh_st0", 16'(dut.state), 16'(ST_WAIT_HIGH));
    pop();
    cyc(64);
    check("wh_st1", 16'(dut.state), 16'(ST_WAIT_HIGH));
    idle(20);
    check("wh_st2", 16'(dut.state), 16'(ST_WAIT_HIGH));
    idle(70);
    check("wh_st3", 16'(dut.state), 16'(ST_IDLE));
    stop_two = 1'b0;

    // break: line low through a whole 8E1 frame
    parity_mode = PAR_EVEN;
    RxD = 1'b0;
    cyc(11 * 64 + 16);
    head("break", 9'h000, 1'b0, 1'b1, 1'b1);
    pop();
    idle(100);
    check("break_st", 16'(dut.state), 16'(ST_IDLE));

    parity_mode = PAR_NONE;
    nine_bit = 1'b1;
    tx({5'd0, 1'b1, 9'h1A5, 1'b0}, 11, -1);
    idle(16);
    head("nine", 9'h1A5, 1'b0, 1'b0, 1'b0);
    pop();

    nine_bit = 1'b0;
    data_bits = 2'b00;
    tx({9'd0, 1'b1, 5'h15, 1'b0}, 7, -1);
    idle(16);
    head("five", 9'h015, 1'b0, 1'b0, 1'b0);
    pop();

    data_bits = 2'b11;
    baud_select = 3'd6;
    bitc = 128;
    tx({6'd0, 1'b1, 8'h3C, 1'b0}, 10, -1);
    idle(16);
    head("b57600", 9'h03C, 1'b0, 1'b0, 1'b0);
    pop();
    baud_select = 3'd7;
    bitc = 64;

    // RX_EN abort keeps queued entry
    tx({6'd0, 1'b1, 8'hA7, 1'b0}, 10, -1);
    idle(16);
    tx(16'd0, 4, -1);
    RX_EN = 1'b0;
    cyc(2);
    check("abort_st", 16'(dut.state), 16'(ST_IDLE));
    idle(10);
    RX_EN = 1'b1;
    idle(200);
    head("abort", 9'h0A7, 1'b0, 1'b0, 1'b0);
    pop();
    check("abort_v", 16'(Rx_VALID), 16'd0);

    // overrun: five frames into four entries
    for (int k = 1; k <= 5; k++) begin
      tx({6'd0, 1'b1, 8'(k * 17), 1'b0}, 10, -1);
      idle(16);
    end
    check("ovr_set", 16'(Rx_OVERRUN), 16'd1);
    for (int k = 1; k <= 4; k++) begin
      head("ovr_q", 9'(k * 17), 1'b0, 1'b0, 1'b0);
      pop();
    end
    check("ovr_drain", 16'(Rx_VALID), 16'd0);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    check("ovr_clr", 16'(Rx_OVERRUN), 16'd0);

    // push and pop on the same edge while full
    for (int k = 1; k <= 4; k++) begin
      tx({6'd0, 1'b1, 8'(8'h60 + k), 1'b0}, 10, -1);
      idle(16);
    end
    tx({6'd0, 1'b1, 8'h65, 1'b0}, 10, -1);
    wait_push(ok);
    check("push_seen0", 16'(ok), 16'd1);
    Rx_READY = 1'b1;
    cyc(1);
    Rx_READY = 1'b0;
    idle(16);
    check("fullpop_ovr", 16'(Rx_OVERRUN), 16'd0);

    // overrun set beats simultaneous clear
    tx({6'd0, 1'b1, 8'h66, 1'b0}, 10, -1);
    wait_push(ok);
    check("push_seen1", 16'(ok), 16'd1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    idle(16);
    check("set_wins", 16'(Rx_OVERRUN), 16'd1);
    for (int k = 2; k <= 5; k++) begin
      head("full_q", 9'(9'h060 + k), 1'b0, 1'b0, 1'b0);
      pop();
    end
    check("full_drain", 16'(Rx_VALID), 16'd0);

    // reset mid-frame flushes everything
    tx({6'd0, 1'b1, 8'h3C, 1'b0}, 10, -1);
    idle(16);
    tx(16'd0, 3, -1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("rst_out",
          16'({Rx_VALID, Rx_OVERRUN, Rx_PERROR,
               Rx_FERROR, Rx_BREAK, Rx_DATA}), 16'd0);
    check("rst_st", 16'(dut.state), 16'(ST_IDLE));
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
